sram_path_router: RTL and testbench

SRAM_PATH_ROUTER -- requirements
Module: sram_path_router

---
 rtl/sram_path_router.sv | 116 +++++++++++
 tb/tb_sram_path_router.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_path_router.sv
// Routes an sram-like CPU request stream to a cache or uncached slave path,
// keeping all outstanding transactions on one path. Optional counters: PATH_STATS_EN.
module sram_path_router #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_cached,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_addr_ok,
  output logic              cpu_data_ok,
  output logic              c_req,
  output logic              c_wr,
  output logic [1:0]        c_size,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_addr_ok,
  input  logic              c_data_ok,
  output logic              u_req,
  output logic              u_wr,
  output logic [1:0]        u_size,
  output logic [ADDR_W-1:0] u_addr,
  output logic [DATA_W-1:0] u_wdata,
  input  logic [DATA_W-1:0] u_rdata,
  input  logic              u_addr_ok,
  input  logic              u_data_ok,
  output logic              idle,
  output logic [31:0]       stat_c_cnt,
  output logic [31:0]       stat_u_cnt,
  output logic [31:0]       stat_stall_cnt
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] outst_q, outst_d;
  logic             opath_q, opath_d;
  logic             gnt, hs, dok;

  // Reset gates the grant so no request escapes while reset is held.
  assign gnt = !reset && cpu_req && (outst_q < MAX_CNT) &&
               ((outst_q == '0) || (opath_q == cpu_cached));
  assign hs  = gnt && (cpu_cached ? c_addr_ok : u_addr_ok);
  assign dok = (outst_q != '0) && (opath_q ? c_data_ok : u_data_ok);

  assign c_req       = gnt && cpu_cached;
  assign u_req       = gnt && !cpu_cached;
  assign cpu_addr_ok = hs;
  assign cpu_data_ok = dok;
  assign cpu_rdata   = opath_q ? c_rdata : u_rdata;
  assign idle        = (outst_q == '0);

  assign c_wr    = cpu_wr;
  assign c_size  = cpu_size;
  assign c_addr  = cpu_addr;
  assign c_wdata = cpu_wdata;
  assign u_wr    = cpu_wr;
  assign u_size  = cpu_size;
  assign u_addr  = cpu_addr;
  assign u_wdata = cpu_wdata;

  always_comb begin
    outst_d = outst_q;
    opath_d = opath_q;
    if (hs) opath_d = cpu_cached;
    if (hs && !dok) outst_d = outst_q + CNT_W'(1);
    else if (!hs && dok) outst_d = outst_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outst_q <= '0;
      opath_q <= 1'b0;
    end else begin
      outst_q <= outst_d;
      opath_q <= opath_d;
    end
  end

`ifdef PATH_STATS_EN
  logic [31:0] stat_c_q, stat_u_q, stat_stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_c_q     <= '0;
      stat_u_q     <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_c_q     <= sat_inc(stat_c_q, hs && cpu_cached);
      stat_u_q     <= sat_inc(stat_u_q, hs && !cpu_cached);
      stat_stall_q <= sat_inc(stat_stall_q, cpu_req && !gnt);
    end
  end

  assign stat_c_cnt     = stat_c_q;
  assign stat_u_cnt     = stat_u_q;
  assign stat_stall_cnt = stat_stall_q;
`else
  assign stat_c_cnt     = 32'd0;
  assign stat_u_cnt     = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sram_path_router.sv
// Bench for sram_path_router: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model.
module tb_sram_path_router;
  localparam int AW = 32, DW = 32, MAXO = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req, cpu_wr, cpu_cached;
  logic [1:0] cpu_size;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic cpu_addr_ok, cpu_data_ok;
  logic c_req, c_wr, c_addr_ok, c_data_ok;
  logic [1:0] c_size;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic u_req, u_wr, u_addr_ok, u_data_ok;
  logic [1:0] u_size;
  logic [AW-1:0] u_addr;
  logic [DW-1:0] u_wdata, u_rdata;
  logic idle;
  logic [31:0] stat_c_cnt, stat_u_cnt, stat_stall_cnt;

  sram_path_router #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_cached(cpu_cached), .cpu_rdata(cpu_rdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
    .c_req(c_req), .c_wr(c_wr), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_addr_ok(c_addr_ok), .c_data_ok(c_data_ok),
    .u_req(u_req), .u_wr(u_wr), .u_size(u_size), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_rdata(u_rdata), .u_addr_ok(u_addr_ok), .u_data_ok(u_data_ok),
    .idle(idle), .stat_c_cnt(stat_c_cnt), .stat_u_cnt(stat_u_cnt),
    .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  // Transaction-level model: how many are in flight, and on which path.
  int m_outst = 0;
  bit m_path = 1'b0;
  int m_c = 0, m_u = 0, m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int stat_exp(input int v);
`ifdef PATH_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic clr_in();
    cpu_req = 0; cpu_wr = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0; cpu_cached = 0;
    c_rdata = 0; c_addr_ok = 0; c_data_ok = 0;
    u_rdata = 0; u_addr_ok = 0; u_data_ok = 0;
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one cycle.
  task automatic cyc(input string tag);
    bit g, hs, dok;
    #1;
    g   = cpu_req && (m_outst < MAXO) && (m_outst == 0 || m_path == cpu_cached);
    hs  = g && (cpu_cached ? c_addr_ok : u_addr_ok);
    dok = (m_outst != 0) && (m_path ? c_data_ok : u_data_ok);
    chk({tag, ":c_req"}, c_req, g && cpu_cached);
    chk({tag, ":u_req"}, u_req, g && !cpu_cached);
    chk({tag, ":addr_ok"}, cpu_addr_ok, hs);
    chk({tag, ":data_ok"}, cpu_data_ok, dok);
    chk({tag, ":idle"}, idle, m_outst == 0);
    if (dok) chk({tag, ":rdata"}, cpu_rdata, m_path ? c_rdata : u_rdata);
    chk({tag, ":pass"}, {c_addr, c_wr, c_size}, {cpu_addr, cpu_wr, cpu_size});
    chk({tag, ":upass"}, {u_wdata, u_wr, u_size}, {cpu_wdata, cpu_wr, cpu_size});
    chk({tag, ":stat_c"}, stat_c_cnt, stat_exp(m_c));
    chk({tag, ":stat_u"}, stat_u_cnt, stat_exp(m_u));
    chk({tag, ":stat_st"}, stat_stall_cnt, stat_exp(m_stall));
    @(posedge clk);
    if (hs) m_path = cpu_cached;
    m_outst = m_outst + int'(hs) - int'(dok);
    if (hs && cpu_cached) m_c++;
    if (hs && !cpu_cached) m_u++;
    if (cpu_req && !g) m_stall++;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    #2;
    cpu_req = 1; cpu_cached = 1; c_addr_ok = 1; c_data_ok = 1; u_data_ok = 1;
    reset = 1;
    #1;
    chk({tag, ":rst_c_req"}, c_req, 0);
    chk({tag, ":rst_u_req"}, u_req, 0);
    chk({tag, ":rst_addr_ok"}, cpu_addr_ok, 0);
    chk({tag, ":rst_data_ok"}, cpu_data_ok, 0);
    chk({tag, ":rst_idle"}, idle, 1);
    chk({tag, ":rst_stats"}, {stat_c_cnt, stat_u_cnt} | 64'(stat_stall_cnt), 0);
    m_outst = 0; m_path = 0; m_c = 0; m_u = 0; m_stall = 0;
    @(negedge clk);
    reset = 0;
    clr_in();
  endtask

  task automatic put(input bit req, input bit cached, input bit cao, input bit cdo,
                     input bit uao, input bit udo);
    cpu_req = req; cpu_cached = cached; c_addr_ok = cao; c_data_ok = cdo;
    u_addr_ok = uao; u_data_ok = udo;
    cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wr = 1'($urandom);
    cpu_size = 2'($urandom); c_rdata = $urandom; u_rdata = $urandom;
  endtask

  initial begin
    clr_in();
    repeat (2) @(negedge clk);
    do_reset("init");

    // Four cached grants fill the window; a same-cycle data_ok does not reopen it.
    for (int i = 0; i < 4; i++) begin put(1, 1, 1, 0, 0, 0); cyc("b2b"); end
    put(1, 1, 1, 0, 0, 0); #1;
    chk("full_c_req", c_req, 0); chk("full_idle", idle, 0);
    cyc("full");
    put(1, 1, 1, 1, 0, 0); #1;
    chk("full_dok_c_req", c_req, 0); chk("full_dok", cpu_data_ok, 1);
    cyc("full_dok");
    put(1, 1, 1, 0, 0, 0); #1;
    chk("fifth_granted", c_req, 1);
    cyc("fifth");

    // Mid-burst reset, then a late data_ok is ignored.
    do_reset("mid");
    put(0, 0, 0, 1, 0, 1); #1;
    chk("late_dok", cpu_data_ok, 0);
    cyc("late");

    // Route change waits for the cached transaction to drain.
    put(1, 1, 1, 0, 0, 0); cyc("rc_c");
    put(1, 0, 0, 0, 1, 0); #1; chk("rc_block1", u_req, 0); cyc("rc1");
    put(1, 0, 0, 1, 1, 0); #1; chk("rc_block2", u_req, 0); cyc("rc2");
    put(1, 0, 0, 0, 1, 0); #1; chk("rc_grant", u_req, 1); cyc("rc3");

    // Response steering with one uncached outstanding.
    put(0, 0, 0, 0, 0, 0);
    c_rdata = 32'hAAAA_AAAA; u_rdata = 32'h5555_5555; c_data_ok = 1; #1;
    chk("stray_c_dok", cpu_data_ok, 0);
    cyc("stray");
    put(0, 0, 0, 0, 0, 1);
    c_rdata = 32'hAAAA_AAAA; u_rdata = 32'h5555_5555; #1;
    chk("steer_rdata", cpu_rdata, 32'h5555_5555);
    chk("steer_dok", cpu_data_ok, 1);
    cyc("steer");

    // Handshake coinciding with data_ok keeps the count at one.
    put(1, 1, 1, 0, 0, 0); cyc("sim0");
    put(1, 1, 1, 1, 0, 0); cyc("sim1");
    put(0, 1, 0, 0, 0, 0); #1; chk("sim_idle", idle, 0); cyc("sim2");
    put(0, 1, 0, 1, 0, 0); cyc("sim3");
    put(0, 1, 0, 0, 0, 0); #1; chk("sim_drained", idle, 1); cyc("sim4");

    // Counter scenario: 3 cached, 2 uncached, 5 stalled cycles.
    do_reset("stats");
    for (int i = 0; i < 3; i++) begin put(1, 1, 1, 0, 0, 0); cyc("st_c"); end
    for (int i = 0; i < 3; i++) begin put(0, 1, 0, 1, 0, 0); cyc("st_cd"); end
    for (int i = 0; i < 2; i++) begin put(1, 0, 0, 0, 1, 0); cyc("st_u"); end
    for (int i = 0; i < 5; i++) begin put(1, 1, 1, 0, 0, 0); cyc("st_stall"); end
    put(0, 0, 0, 0, 0, 0); #1;
    chk("stat_c_final", stat_c_cnt, stat_exp(3));
    chk("stat_u_final", stat_u_cnt, stat_exp(2));
    chk("stat_stall_final", stat_stall_cnt, stat_exp(5));
    cyc("st_end");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      put(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0) ? m_path : ~m_path,
          1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 2) == 0));
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
